// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM
// state type and a one-hot helper.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Convert a requester index into its one-hot grant vector.
    function automatic logic [N_REQ-1:0] onehot8(input logic [ID_W-1:0] id);
        onehot8 = {{(N_REQ-1){1'b0}}, 1'b1} << id;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// 8-bit priority encoder: lowest set bit wins. With no bit set, idx is 0
// and any is 0.
module prio_enc8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] in,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (in[i]) begin
                idx = ID_W'(i);
            end
        end
    end

    assign any = |in;

endmodule

// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter for 8 requesters. A requester holds req high for as
// long as it owns the resource. The grant is registered, one-hot or zero,
// and grant_id carries the owner's index for the datapath mux.
// Handshake: req is a level; ownership starts on the edge where grant is
// loaded and ends on the first edge where the owner's req is sampled low.
// Handoff to the next requester happens on that same edge (no idle gap).
// Optional feature macro: ARB_GRANT_TIMEOUT_EN -- bounds each tenure to
// MAX_HOLD cycles and locks the evicted owner out until it drops req.
module rr_priority_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_valid,
    output logic             timeout
);

    arb_state_t       state;
    logic [ID_W-1:0]  last_id;
    logic [N_REQ-1:0] lockout;
    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] masked;
    logic             owner_req;
    logic             force_rel;
    logic [ID_W-1:0]  m_idx;
    logic [ID_W-1:0]  r_idx;
    logic             m_any;
    logic             r_any;
    logic [ID_W-1:0]  winner;
    logic             new_grant;

    // Counter must be able to hold MAX_HOLD-1; the encoder is 8 wide.
    if ((2 ** CNT_W) <= MAX_HOLD || N_REQ != 8) begin : g_cfg_check
        $error("rr_priority_arbiter: need N_REQ==8 and 2**CNT_W > MAX_HOLD");
    end

    assign owner_req = |(req & grant);

`ifdef ARB_GRANT_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;

    assign force_rel = (state == BUSY) && owner_req &&
                       (hold_cnt == CNT_W'(MAX_HOLD - 1));

    // Tenure counter, lockout mask and the one-cycle timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            lockout  <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= force_rel;
            lockout <= (lockout & req) | (force_rel ? grant : '0);
            if (new_grant) begin
                hold_cnt <= '0;
            end else if (state == BUSY) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign lockout   = '0;
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    // A forcibly released owner still has req high, so drop it explicitly.
    assign cand = req & ~lockout & ~(force_rel ? grant : '0);

    // Keep only candidates strictly above the previous winner.
    always_comb begin
        masked = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) > last_id) begin
                masked[i] = cand[i];
            end
        end
    end

    prio_enc8 u_enc_masked (
        .in  (masked),
        .idx (m_idx),
        .any (m_any)
    );

    prio_enc8 u_enc_raw (
        .in  (cand),
        .idx (r_idx),
        .any (r_any)
    );

    assign winner    = m_any ? m_idx : r_idx;
    assign new_grant = r_any && ((state == IDLE) || !owner_req || force_rel);

    // Arbitration FSM with registered grant, grant_id and rotation pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            last_id  <= ID_W'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (r_any) begin
                        state    <= BUSY;
                        grant    <= onehot8(winner);
                        grant_id <= winner;
                        last_id  <= winner;
                    end
                end
                BUSY: begin
                    if (!owner_req || force_rel) begin
                        if (r_any) begin
                            grant    <= onehot8(winner);
                            grant_id <= winner;
                            last_id  <= winner;
                        end else begin
                            state    <= IDLE;
                            grant    <= '0;
                            grant_id <= '0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= '0;
                    grant_id <= '0;
                end
            endcase
        end
    end

    assign grant_valid = |grant;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Bench for rr_priority_arbiter. Directed scenarios plus a random phase;
// a rotation-based reference model predicts every cycle's outputs into a
// queue which a monitor pops and compares. Honours ARB_GRANT_TIMEOUT_EN.
module tb_rr_priority_arbiter;

    localparam int MAXH = 4;
`ifdef ARB_GRANT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int n_vec = 0;
    int n_err = 0;

    // expected word: {timeout, valid, id, grant}
    logic [12:0] exp_q[$];

    // reference model state
    int         m_owner = -1;
    int         m_last  = 7;
    int         m_hold  = 0;
    logic [7:0] m_lock  = 8'h00;

    rr_priority_arbiter #(
        .MAX_HOLD (MAXH),
        .CNT_W    (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin pick: first eligible index after last, wrapping mod 8.
    function automatic int pick(input logic [7:0] c, input int last);
        for (int k = 1; k <= 8; k++) begin
            if (c[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    // Model reset tracks the DUT's asynchronous reset.
    initial forever begin
        @(negedge rst_n);
        m_owner = -1;
        m_last  = 7;
        m_hold  = 0;
        m_lock  = 8'h00;
        exp_q.delete();
    end

    // Reference model: one step per rising edge, pushes the expected outputs.
    always @(posedge clk) begin
        logic [7:0] r;
        logic [7:0] c;
        logic [7:0] nl;
        bit         held;
        bit         forced;
        int         w;
        if (rst_n) begin
            r      = req;
            c      = r & ~m_lock;
            held   = 1'b0;
            forced = 1'b0;
            if (m_owner >= 0) begin
                held = r[m_owner];
                if (held && TO_EN && m_hold == MAXH - 1) forced = 1'b1;
            end
            nl = 8'h00;
            if (TO_EN) begin
                nl = m_lock & r;
                if (forced) nl[m_owner] = 1'b1;
            end
            if (m_owner < 0 || !held || forced) begin
                if (forced) c[m_owner] = 1'b0;
                w = pick(c, m_last);
                if (w >= 0) begin
                    m_owner = w;
                    m_last  = w;
                    m_hold  = 0;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_hold++;
            end
            m_lock = nl;
            if (m_owner >= 0)
                exp_q.push_back({forced, 1'b1, 3'(m_owner), 8'(8'h01 << m_owner)});
            else
                exp_q.push_back({forced, 1'b0, 3'd0, 8'h00});
        end
    end

    // Monitor: compare DUT outputs against the scoreboard each cycle.
    initial forever begin
        logic [12:0] e;
        logic [12:0] a;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {timeout, grant_valid, (grant_valid ? grant_id : 3'd0), grant};
            check("monitor", 32'(a), 32'(e));
        end
    end

    // driver tasks
    task automatic drive(input logic [7:0] v);
        @(negedge clk);
        req = v;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_grant", 32'(grant), 32'h00);
        check("reset_valid", 32'(grant_valid), 32'h0);
        check("reset_timeout", 32'(timeout), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        settle();
        check("first_grant", 32'(grant), 32'h01);
        check("first_id", 32'(grant_id), 32'h0);

        // rotation: owner drops req for one cycle each tenure
        for (int i = 1; i <= 8; i++) begin
            drive(8'hFF & ~grant);
            settle();
            check("rot_id", 32'(grant_id), 32'(i % 8));
            check("rot_valid", 32'(grant_valid), 32'h1);
        end
        drive(8'h00);
        settle();
        check("idle_grant", 32'(grant), 32'h00);

        // wrap and mask from last_id=5
        drive(8'h20);
        settle();
        check("wrap_setup_id", 32'(grant_id), 32'h5);
        drive(8'h00);
        settle();
        drive(8'b0000_0110);
        settle();
        check("wrap_id", 32'(grant_id), 32'h1);
        drive(8'b0100_0100);
        settle();
        check("mask_id", 32'(grant_id), 32'h2);
        drive(8'h00);
        settle();

        // idle and sole requester
        drive(8'h08);
        settle();
        check("sole_grant", 32'(grant), 32'h08);
        drive(8'h00);
        settle();
        check("sole_release", 32'(grant), 32'h00);
        drive(8'h08);
        settle();
        check("sole_regrant_id", 32'(grant_id), 32'h3);
        drive(8'h00);
        settle();

        // async reset mid-grant
        drive(8'h10);
        settle();
        check("async_pre_grant", 32'(grant), 32'h10);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_grant", 32'(grant), 32'h00);
        check("async_valid", 32'(grant_valid), 32'h0);
        @(negedge clk);
        req   = 8'h00;
        rst_n = 1'b1;

        // bounded tenure (plain hold when the feature is off)
        drive(8'h03);
        settle();
        check("hold_start", 32'(grant), 32'h01);
        repeat (4) @(posedge clk);
        #1;
        check("hold_timeout", 32'(timeout), TO_EN ? 32'h1 : 32'h0);
        check("hold_grant", 32'(grant), TO_EN ? 32'h02 : 32'h01);
        drive(8'h00);
        settle();

        // random phase: requests change occasionally so tenures vary
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255));
        end
        drive(8'h00);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) check("drain", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
